// File: rtl/comparador_pkg.sv
// Shared types and constants for the equality-comparator BIST.
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } bist_state_t;

  localparam logic [31:0] LFSR_TAPS    = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE11234;

endpackage

// File: rtl/bist_lfsr.sv
// Right-shifting Galois LFSR with synchronous reload to SEED.
module bist_lfsr #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter logic [WIDTH-1:0] TAPS  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (step) begin
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/comparador_bist.sv
// BIST driver/checker for the equality comparator: even vectors drive equal
// operands, odd vectors flip one bit, and each result is checked one cycle later.
module comparador_bist
  import comparador_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      NUM_VECTORS = 16,
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(DEFAULT_SEED)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic [WIDTH-1:0]                   cmp_a,
  output logic [WIDTH-1:0]                   cmp_b,
  input  logic                               cmp_s,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   err_count,
  output logic [$clog2(NUM_VECTORS)-1:0]     fail_index
);

  localparam int unsigned     EW       = $clog2(NUM_VECTORS + 1);
  localparam int unsigned     IW       = $clog2(NUM_VECTORS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_VECTORS - 1);

  bist_state_t       state;
  logic [IW-1:0]     idx;
  logic [WIDTH-1:0]  lfsr_value;
  logic [WIDTH-1:0]  flip_mask;
  logic              accept;
  logic              mismatch;
  logic [EW-1:0]     err_next;

  bist_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .TAPS  (WIDTH'(LFSR_TAPS))
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (state == SAMPLE),
    .value (lfsr_value)
  );

  always_comb begin
    accept   = ((state == IDLE) || (state == DONE)) && start;
    // Even vectors expect equality, odd vectors expect a difference.
    mismatch = (cmp_s != ~idx[0]);
    err_next = err_count + EW'(mismatch);
    flip_mask = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      flip_mask[b] = ((32'(idx) % WIDTH) == b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_index <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_index <= '0;
            idx        <= '0;
          end
        end
        DRIVE: begin
          cmp_a <= lfsr_value;
          cmp_b <= lfsr_value ^ (idx[0] ? flip_mask : '0);
          state <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_next;
            if (err_count == '0) begin
              fail_index <= idx;
            end
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            idx   <= idx + IW'(1);
            state <= DRIVE;
          end
        end
      endcase
    end
  end

endmodule
